// File: rtl/main_memory_responder.sv
// Memory-side responder for the cache MStrobe/MRW interface: fixed-latency block reads
// and single-word write-through commits against an internal word array.
module main_memory_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int WORDS   = 4,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       MStrobe,
    input  logic                                       MRW,
    input  logic [ADDR_W-1:0]                          MAddr,
    input  logic [DATA_W-1:0]                          MDataIn,
    output logic                                       MBusy,
    output logic                                       MDataValid,
    output logic [DATA_W-1:0]                          MDataOut,
    output logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] MWordIdx,
    output logic                                       MRdy
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RDXF, WRAK} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic              latch;
    logic              rw;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (MStrobe) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(LATENCY - 1);
                    idx_nxt   = '0;
                    latch     = 1'b1;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = rw ? WRAK : RDXF;
                    idx_nxt   = '0;
                end
            end
            RDXF: begin
                if (idx == IDX_LAST) state_nxt = IDLE;
                else                 idx_nxt   = idx + IW'(1);
            end
            WRAK:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst address wraps in ADDR_W bits first, then aliases into the array
    assign rd_addr = base + ADDR_W'(idx_nxt);
    assign rd_ptr  = rd_addr[AW-1:0];

    generate
        if (AW < ADDR_W) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^rd_addr[ADDR_W-1:AW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            rw         <= 1'b0;
            base       <= '0;
            wdata      <= '0;
            MBusy      <= 1'b0;
            MDataValid <= 1'b0;
            MDataOut   <= '0;
            MWordIdx   <= '0;
            MRdy       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (latch) begin
                rw    <= MRW;
                base  <= MRW ? MAddr : (MAddr & BLK_MASK);
                wdata <= MDataIn;
            end
            MBusy      <= (state_nxt != IDLE);
            MDataValid <= (state_nxt == RDXF);
            MDataOut   <= (state_nxt == RDXF) ? mem[rd_ptr] : '0;
            MWordIdx   <= (state_nxt == RDXF) ? idx_nxt : '0;
            MRdy       <= (state_nxt == WRAK) || ((state_nxt == RDXF) && (idx_nxt == IDX_LAST));
        end
    end

    // Storage is deliberately not reset; a write commits on the edge that leaves WRAK
    always_ff @(posedge clk) begin
        if (state == WRAK) mem[base[AW-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: scoreboarded block reads, writes,
// ignored strobes, mid-operation resets and a LATENCY=1/WORDS=1 aliasing instance.
module tb_main_memory_responder;

    localparam int L = 4;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mstrobe = 1'b0, mrw = 1'b0;
    logic [15:0] maddr = '0;
    logic [31:0] mdin = '0;
    logic        mbusy, mvalid, mrdy;
    logic [31:0] mdout;
    logic [1:0]  midx;

    logic        mstrobe_b = 1'b0, mrw_b = 1'b0;
    logic [15:0] maddr_b = '0;
    logic [31:0] mdin_b = '0;
    logic        mbusy_b, mvalid_b, mrdy_b;
    logic [31:0] mdout_b;
    logic [0:0]  midx_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model [256];
    logic [33:0] sbq [$];

    always #5 clk = ~clk;

    main_memory_responder #(.ADDR_W(16), .DATA_W(32), .WORDS(W), .LATENCY(L), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .MStrobe(mstrobe), .MRW(mrw), .MAddr(maddr), .MDataIn(mdin),
        .MBusy(mbusy), .MDataValid(mvalid), .MDataOut(mdout), .MWordIdx(midx), .MRdy(mrdy));

    main_memory_responder #(.ADDR_W(16), .DATA_W(32), .WORDS(1), .LATENCY(1), .DEPTH(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .MStrobe(mstrobe_b), .MRW(mrw_b), .MAddr(maddr_b), .MDataIn(mdin_b),
        .MBusy(mbusy_b), .MDataValid(mvalid_b), .MDataOut(mdout_b), .MWordIdx(midx_b), .MRdy(mrdy_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input int rst_at);
        @(negedge clk);
        mstrobe = 1'b1; mrw = 1'b1; maddr = addr; mdin = data;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (k == 1) mstrobe = 1'b0;
            chk("wr_busy", mbusy, 1);
            chk("wr_valid", mvalid, 0);
            chk("wr_rdy", mrdy, (k == L + 1));
            if (rst_at == k) begin
                rst_n = 1'b0;
                #1;
                chk("wr_rst_busy", mbusy, 0);
                chk("wr_rst_rdy", mrdy, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        model[addr[7:0]] = data;
        @(negedge clk);
        chk("wr_idle", mbusy, 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input bit pulse2, input int rst_at);
        logic [15:0] base;
        logic [33:0] e;
        int          nrdy;
        nrdy = 0;
        base = addr & 16'hFFFC;
        for (int i = 0; i < W; i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            sbq.push_back({2'(i), model[a[7:0]]});
        end
        @(negedge clk);
        mstrobe = 1'b1; mrw = 1'b0; maddr = addr;
        for (int k = 1; k <= L + W; k++) begin
            @(negedge clk);
            if (k == 1) mstrobe = 1'b0;
            if (k == 2 && pulse2) mstrobe = 1'b1;
            if (k == 3) mstrobe = 1'b0;
            chk("rd_busy", mbusy, 1);
            chk("rd_valid", mvalid, (k > L));
            chk("rd_rdy", mrdy, (k == L + W));
            if (mrdy) nrdy++;
            if (mvalid) begin
                if (sbq.size() == 0) begin
                    chk("rd_sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rd_idx", midx, e[33:32]);
                    chk("rd_data", mdout, e[31:0]);
                end
            end else begin
                chk("rd_dout_zero", mdout, 0);
            end
            if (rst_at == k) begin
                rst_n = 1'b0;
                #1;
                chk("rd_rst_busy", mbusy, 0);
                chk("rd_rst_valid", mvalid, 0);
                chk("rd_rst_rdy", mrdy, 0);
                sbq.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rd_after_busy", mbusy, 0);
            if (mrdy) nrdy++;
        end
        chk("rd_rdy_count", nrdy, 1);
        chk("rd_sb_drained", sbq.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", mbusy, 0);
        chk("rst_valid", mvalid, 0);
        chk("rst_rdy", mrdy, 0);
        chk("rst_dout", mdout, 0);
        chk("rst_idx", midx, 0);
        chk("rst_b_busy", mbusy_b, 0);
        rst_n = 1'b1;

        // Preload block 8..11 through the write path, then read with unaligned address
        for (int i = 0; i < 4; i++) do_write(16'(8 + i), 32'hA0A0_0000 + 32'(i), 0);
        do_read(16'd10, 1'b0, 0);

        do_write(16'd4, 32'h4444_0004, 0);
        do_write(16'd6, 32'h6666_0006, 0);
        do_write(16'd7, 32'h7777_0007, 0);
        do_write(16'd5, 32'hDEAD_BEEF, 0);
        do_read(16'd4, 1'b0, 0);

        do_read(16'd8, 1'b1, 0);

        do_read(16'd4, 1'b0, 6);
        do_read(16'd9, 1'b0, 0);

        do_write(16'd7, 32'h0000_1234, 3);
        do_read(16'd7, 1'b0, 0);

        // Single-word, single-cycle-latency instance with address aliasing
        @(negedge clk);
        mstrobe_b = 1'b1; mrw_b = 1'b1; maddr_b = 16'd5; mdin_b = 32'h55AA_1234;
        @(negedge clk);
        mstrobe_b = 1'b0;
        chk("b_wr_busy", mbusy_b, 1);
        chk("b_wr_rdy_early", mrdy_b, 0);
        @(negedge clk);
        chk("b_wr_rdy", mrdy_b, 1);
        chk("b_wr_valid", mvalid_b, 0);
        @(negedge clk);
        chk("b_wr_idle", mbusy_b, 0);
        mstrobe_b = 1'b1; mrw_b = 1'b0; maddr_b = 16'h0105;
        @(negedge clk);
        mstrobe_b = 1'b0;
        chk("b_rd_wait_valid", mvalid_b, 0);
        chk("b_rd_wait_busy", mbusy_b, 1);
        @(negedge clk);
        chk("b_rd_valid", mvalid_b, 1);
        chk("b_rd_rdy", mrdy_b, 1);
        chk("b_rd_data", mdout_b, 32'h55AA_1234);
        chk("b_rd_idx", midx_b, 0);
        @(negedge clk);
        chk("b_rd_idle", mbusy_b, 0);
        chk("b_rd_dout_zero", mdout_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
